// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: RV32I widths, the
// load opcode and the sequencer state encoding.
// Latency: n/a (types and constants only). Backpressure: n/a.
package pipeline_hazard_ctrl_pkg;

  localparam int XLEN  = 32;  // architectural register / PC width
  localparam int XADDR = 5;   // register-file address width
  localparam int OPLEN = 6;   // opcode MSB index (opcode is OPLEN+1 bits)

  // RV32I LOAD major opcode
  localparam logic [OPLEN:0] L_OP = 7'b0000011;

  // Sequencer states; the encoding is visible on o_state for debug.
  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_LU_STALL = 2'd1,
    HZ_FLUSH    = 2'd2,
    HZ_MEM_WAIT = 2'd3
  } hz_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use detector: flags an ID instruction that reads the rd of a load in EX.
// Latency: purely combinational, same cycle.
// Backpressure: none; the caller decides whether to act on the flag.
//
// Ports:
//   i_id_rs1_addr/i_id_rs2_addr  source registers of the ID instruction
//   i_id_rs1_used/i_id_rs2_used  which sources are really read
//   i_ex_opcode/i_ex_rd_addr     opcode and destination of the EX instruction
//   o_lu                         load-use hazard present
module load_use_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [XADDR-1:0] i_id_rs1_addr,
  input  logic [XADDR-1:0] i_id_rs2_addr,
  input  logic             i_id_rs1_used,
  input  logic             i_id_rs2_used,
  input  logic [OPLEN:0]   i_ex_opcode,
  input  logic [XADDR-1:0] i_ex_rd_addr,
  output logic             o_lu
);

  logic ex_is_load;
  logic rs1_hit;
  logic rs2_hit;

  // x0 is hardwired to zero, so a load into x0 can never create a hazard.
  assign ex_is_load = (i_ex_opcode == L_OP) && (i_ex_rd_addr != '0);
  assign rs1_hit    = i_id_rs1_used && (i_id_rs1_addr == i_ex_rd_addr);
  assign rs2_hit    = i_id_rs2_used && (i_id_rs2_addr == i_ex_rd_addr);
  assign o_lu       = ex_is_load && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline (load-use, redirect, dmem wait).
// Latency: control outputs are combinational from state+inputs (same cycle); state is registered.
// Backpressure: a pending data-memory access stalls all four stage registers until i_dmem_ready.
//
// Ports: i_clk, i_rst_n (synchronous, active-low); ID source regs / EX opcode+rd for
// load-use; i_redirect/i_redirect_pc from the EX/MEM register; i_dmem_req/i_dmem_ready
// from MEM; per-stage o_stall_* / o_flush_*, fetch mux o_pc_sel/o_pc_target, debug
// o_state, sticky watchdog o_mem_timeout.
// Optional build macro HAZARD_PERF_CNT_EN adds parameter CNT_W and saturating
// counters o_cnt_lu, o_cnt_flush, o_cnt_memwait.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int IMEM_LAT = 1,
  parameter int WAIT_MAX = 255
`ifdef HAZARD_PERF_CNT_EN
  ,
  parameter int CNT_W    = 32
`endif
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [XADDR-1:0] i_id_rs1_addr,
  input  logic [XADDR-1:0] i_id_rs2_addr,
  input  logic             i_id_rs1_used,
  input  logic             i_id_rs2_used,
  input  logic [OPLEN:0]   i_ex_opcode,
  input  logic [XADDR-1:0] i_ex_rd_addr,
  input  logic             i_redirect,
  input  logic [XLEN-1:0]  i_redirect_pc,
  input  logic             i_dmem_req,
  input  logic             i_dmem_ready,
  output logic             o_stall_if,
  output logic             o_stall_id,
  output logic             o_stall_ex,
  output logic             o_stall_mem,
  output logic             o_flush_id,
  output logic             o_flush_ex,
  output logic             o_pc_sel,
  output logic [XLEN-1:0]  o_pc_target,
  output logic [1:0]       o_state,
  output logic             o_mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] o_cnt_lu,
  output logic [CNT_W-1:0] o_cnt_flush,
  output logic [CNT_W-1:0] o_cnt_memwait
`endif
);

  localparam logic [7:0] IMEM_LAT_C = IMEM_LAT[7:0];
  localparam logic [7:0] WAIT_MAX_C = WAIT_MAX[7:0];

  hz_state_t  state, state_nxt;
  logic [7:0] flush_cnt, flush_cnt_nxt;
  logic       flush_resume, flush_resume_nxt;  // FLUSH was interrupted by a dmem wait
  logic [7:0] wait_cnt;
  logic       timeout_q;

  logic memwait;
  logic lu;

  assign memwait = i_dmem_req && !i_dmem_ready;

  load_use_detect u_lu (
    .i_id_rs1_addr (i_id_rs1_addr),
    .i_id_rs2_addr (i_id_rs2_addr),
    .i_id_rs1_used (i_id_rs1_used),
    .i_id_rs2_used (i_id_rs2_used),
    .i_ex_opcode   (i_ex_opcode),
    .i_ex_rd_addr  (i_ex_rd_addr),
    .o_lu          (lu)
  );

  // ------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= HZ_RUN;
      flush_cnt    <= '0;
      flush_resume <= 1'b0;
    end else begin
      state        <= state_nxt;
      flush_cnt    <= flush_cnt_nxt;
      flush_resume <= flush_resume_nxt;
    end
  end

  // ------------------------------------------------------------------
  // Next-state logic. Priority everywhere: memwait > redirect > load-use.
  // ------------------------------------------------------------------
  always_comb begin
    state_nxt        = state;
    flush_cnt_nxt    = flush_cnt;
    flush_resume_nxt = flush_resume;
    unique case (state)
      HZ_RUN, HZ_LU_STALL: begin
        if (memwait) begin
          state_nxt        = HZ_MEM_WAIT;
          flush_resume_nxt = 1'b0;
        end else if (i_redirect) begin
          state_nxt     = HZ_FLUSH;
          flush_cnt_nxt = IMEM_LAT_C;
        end else if (lu && (state == HZ_RUN)) begin
          // LU_STALL is a single cycle: a hazard seen while in it is the
          // same load, now moving into MEM, so it is not re-armed.
          state_nxt = HZ_LU_STALL;
        end else begin
          state_nxt = HZ_RUN;
        end
      end
      HZ_FLUSH: begin
        if (memwait) begin
          // Freeze the flush sequence; it picks up where it left off.
          state_nxt        = HZ_MEM_WAIT;
          flush_resume_nxt = 1'b1;
        end else if (i_redirect) begin
          state_nxt     = HZ_FLUSH;
          flush_cnt_nxt = IMEM_LAT_C;
        end else begin
          flush_cnt_nxt = flush_cnt - 8'd1;
          state_nxt     = (flush_cnt <= 8'd1) ? HZ_RUN : HZ_FLUSH;
        end
      end
      HZ_MEM_WAIT: begin
        // A redirect waiting in MEM is deliberately not taken on the ready
        // cycle; it is handled once, from RUN, on the following cycle.
        if (!memwait) begin
          state_nxt        = flush_resume ? HZ_FLUSH : HZ_RUN;
          flush_resume_nxt = 1'b0;
        end
      end
      default: state_nxt = HZ_RUN;
    endcase
  end

  // ------------------------------------------------------------------
  // Output logic (combinational so hazards act in the cycle they appear)
  // ------------------------------------------------------------------
  always_comb begin
    o_stall_if  = 1'b0;
    o_stall_id  = 1'b0;
    o_stall_ex  = 1'b0;
    o_stall_mem = 1'b0;
    o_flush_id  = 1'b0;
    o_flush_ex  = 1'b0;
    o_pc_sel    = 1'b0;
    o_pc_target = '0;
    unique case (state)
      HZ_RUN, HZ_LU_STALL, HZ_FLUSH: begin
        if (memwait) begin
          {o_stall_if, o_stall_id, o_stall_ex, o_stall_mem} = 4'b1111;
        end else if (i_redirect) begin
          // Only younger stages are flushed; the redirecting instruction
          // itself is in MEM and still retires (JAL/JALR link value).
          o_pc_sel    = 1'b1;
          o_pc_target = i_redirect_pc;
          o_flush_id  = 1'b1;
          o_flush_ex  = 1'b1;
        end else if (state == HZ_FLUSH) begin
          o_flush_id = 1'b1;  // kill fetches issued before the redirect
        end else if (lu && (state == HZ_RUN)) begin
          o_stall_if = 1'b1;
          o_stall_id = 1'b1;
          o_flush_ex = 1'b1;
        end
      end
      HZ_MEM_WAIT: begin
        if (memwait) begin
          {o_stall_if, o_stall_id, o_stall_ex, o_stall_mem} = 4'b1111;
        end
      end
      default: ;
    endcase
    // Reset dominates so the pipeline sees a quiet controller while held.
    if (!i_rst_n) begin
      {o_stall_if, o_stall_id, o_stall_ex, o_stall_mem} = 4'b0000;
      o_flush_id  = 1'b0;
      o_flush_ex  = 1'b0;
      o_pc_sel    = 1'b0;
      o_pc_target = '0;
    end
  end

  // ------------------------------------------------------------------
  // Memory-wait watchdog. Counts consecutive memwait cycles, including the
  // cycle in which the wait is first seen; saturates at WAIT_MAX.
  // ------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else if (memwait) begin
      if (wait_cnt != WAIT_MAX_C) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (wait_cnt >= WAIT_MAX_C - 8'd1) begin
        timeout_q <= 1'b1;
      end
    end else begin
      wait_cnt <= '0;
    end
  end

  assign o_mem_timeout = timeout_q;
  assign o_state       = state;

`ifdef HAZARD_PERF_CNT_EN
  // ------------------------------------------------------------------
  // Saturating performance counters
  // ------------------------------------------------------------------
  logic ev_lu;
  logic ev_flush;

  assign ev_lu    = (state == HZ_RUN) && !memwait && !i_redirect && lu;
  assign ev_flush = o_flush_id;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_cnt_lu      <= '0;
      o_cnt_flush   <= '0;
      o_cnt_memwait <= '0;
    end else begin
      if (ev_lu && (o_cnt_lu != '1)) begin
        o_cnt_lu <= o_cnt_lu + 1'b1;
      end
      if (ev_flush && (o_cnt_flush != '1)) begin
        o_cnt_flush <= o_cnt_flush + 1'b1;
      end
      if (memwait && (o_cnt_memwait != '1)) begin
        o_cnt_memwait <= o_cnt_memwait + 1'b1;
      end
    end
  end
`endif

endmodule
